// File: rtl/vec_seq_pkg.sv
// Shared types and helpers for the vector sequencer.
//   state_e    : sequencer FSM states
//   calc_aw    : address width for a buffer of 'depth' entries (at least 1 bit)
//   golden_dec : behavioural reference for the decrement datapath, w-1 mod 2^width
package vec_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // A one-entry buffer still needs a one-bit address port.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Plain arithmetic reference, kept independent of the ripple-borrow datapath.
  function automatic logic [31:0] golden_dec(input logic [31:0] w, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (w - 32'd1) & mask;
  endfunction

endpackage

// File: rtl/dec_unit.sv
// Combinational WIDTH-bit decrement datapath: dout = din - 1 mod 2^WIDTH.
// Ports:
//   din_i  : input word
//   dout_o : decremented word
module dec_unit #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  // Ripple-borrow chain: bit 0 always flips, and each higher bit flips only
  // while every bit below it was zero (the borrow is still propagating).
  always_comb begin : ripple
    logic borrow;
    borrow = 1'b1;
    dout_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dout_o[i] = din_i[i] ^ borrow;
      borrow    = borrow & ~din_i[i];
    end
  end

endmodule

// File: rtl/vec_seq_ctrl.sv
// Batch sequencer: steps stored stimulus words through dec_unit, stores each
// result and counts results that disagree with the golden decrement.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   wr_en/addr/data   : stimulus buffer write port (ignored while busy)
//   start, num_vec    : launch a run of num_vec vectors (clamped to DEPTH)
//   inj_fault         : flips bit 0 of the captured result
//   rd_addr, rd_data  : registered result buffer read, 1-cycle latency
//   busy, done        : run in progress / run complete
//   err_cnt           : mismatch count of the last or current run
module vec_seq_ctrl
  import vec_seq_pkg::*;
#(
  parameter  int WIDTH  = 2,
  parameter  int DEPTH  = 16,
  parameter  int SETTLE = 1,
  localparam int AW     = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW:0]      num_vec,
  input  logic             inj_fault,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      err_cnt
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [AW:0]   DEPTH_W     = (AW + 1)'(DEPTH);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      num_q, num_d;
  logic [AW:0]      err_q, err_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_q;

  logic [WIDTH-1:0] stim_mem [DEPTH];
  logic [WIDTH-1:0] res_mem  [DEPTH];

  logic [WIDTH-1:0] dut_out;
  logic [WIDTH-1:0] res;
  logic             mismatch;
  logic [AW:0]      num_clamp;

  // The datapath only ever sees the registered input word.
  dec_unit #(.WIDTH(WIDTH)) u_dec (
    .din_i  (din_q),
    .dout_o (dut_out)
  );

  assign res       = dut_out ^ WIDTH'(inj_fault);
  assign mismatch  = (res != WIDTH'(golden_dec(32'(din_q), WIDTH)));
  assign num_clamp = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;

  assign busy    = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign done    = (state_q == ST_DONE);
  assign err_cnt = err_q;
  assign rd_data = rd_q;

  // Next-state and datapath-register logic. A start is only honoured from
  // IDLE or DONE; a zero-length run goes straight to DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    err_d   = err_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_d   = num_clamp;
          err_d   = '0;
          idx_d   = '0;
          state_d = (num_clamp == '0) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        din_d   = stim_mem[idx_q];
        cnt_d   = '0;
        state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_CAPTURE: begin
        // At most DEPTH mismatches per run, which always fits in AW+1 bits.
        if (mismatch) begin
          err_d = err_q + (AW + 1)'(1);
        end
        if ({1'b0, idx_q} == num_q - (AW + 1)'(1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      err_q   <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      err_q   <= err_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      rd_q    <= res_mem[rd_addr];
    end
  end

  // Buffers are never cleared by reset. A write in the same cycle as start
  // lands before APPLY reads the word, so the run sees the new value.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      stim_mem[wr_addr] <= wr_data;
    end
    if (!rst && (state_q == ST_CAPTURE)) begin
      res_mem[idx_q] <= res;
    end
  end

endmodule
